// File: rtl/exc_sequencer.sv
// exc_sequencer
// Sequences the precise exception / ERET flow at the MEM stage.
//   - Chooses the highest-priority pending request (interrupt, then the
//     synchronous exceptions, then ERET) while idle.
//   - Holds flush+stall for FLUSH_CYCLES, then issues one cycle of CP0
//     update strobes, then presents the new fetch PC to IF over a
//     valid/ready handshake.
// Optional feature macro: EXC_SEQ_COUNT_EN (taken-exception counter on
// exc_count; when undefined exc_count is tied to 0).
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   mem_*                  MEM-stage instruction, PC, delay-slot flag,
//                          faulting address, exception bits, ERET flag
//   hw_int, sw_int         raw hardware lines, Cause.IP[1:0]
//   status_im/ie/exl, epc_in  CP0 Status fields and current EPC
//   redirect_ready         IF accepts the redirect
//   flush, stall, busy     pipeline control / sequencer activity
//   redirect_valid/pc      new fetch PC handshake
//   cp0_*                  CP0 write strobes and data
//   exc_count              taken-exception counter
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay,
  input  logic [31:0] mem_badvaddr,
  input  logic [5:0]  mem_exc,
  input  logic        mem_eret,
  input  logic [5:0]  hw_int,
  input  logic [1:0]  sw_int,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc_in,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_we,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_epc_we,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_clr_exl,
  output logic        busy,
  output logic [31:0] exc_count
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [5:0]  hw_meta;
  logic [5:0]  hw_s;
  logic        is_eret;
  logic        is_adr;
  logic        epc_upd;
  logic [31:0] tgt;

  logic        int_pend;
  logic        win_exc;
  logic        win_adr;
  logic [4:0]  win_code;
  logic        capture;

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hw_meta <= '0;
      hw_s    <= '0;
    end else begin
      hw_meta <= hw_int;
      hw_s    <= hw_meta;
    end
  end

  // IM[7:2] masks the synchronised hardware lines, IM[1:0] the software ones.
  assign int_pend = (|({hw_s, sw_int} & status_im)) & status_ie & ~status_exl;

  always_comb begin
    win_exc  = 1'b1;
    win_adr  = 1'b0;
    win_code = 5'd0;
    if (int_pend) begin
      win_code = 5'd0;
    end else if (mem_exc[0]) begin
      win_code = 5'd4;
      win_adr  = 1'b1;
    end else if (mem_exc[1]) begin
      win_code = 5'd5;
      win_adr  = 1'b1;
    end else if (mem_exc[2]) begin
      win_code = 5'd10;
    end else if (mem_exc[3]) begin
      win_code = 5'd12;
    end else if (mem_exc[4]) begin
      win_code = 5'd8;
    end else if (mem_exc[5]) begin
      win_code = 5'd9;
    end else begin
      win_exc  = 1'b0;
    end
  end

  assign capture = (state == IDLE) && mem_valid && (win_exc || mem_eret);
  assign busy    = (state != IDLE);

  // Single sequencer process; every output is registered alongside the
  // state it belongs to so outputs line up with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      flush           <= 1'b0;
      stall           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      cp0_we          <= 1'b0;
      cp0_exccode     <= '0;
      cp0_epc_we      <= 1'b0;
      cp0_epc         <= '0;
      cp0_bd          <= 1'b0;
      cp0_badvaddr_we <= 1'b0;
      cp0_badvaddr    <= '0;
      cp0_clr_exl     <= 1'b0;
      is_eret         <= 1'b0;
      is_adr          <= 1'b0;
      epc_upd         <= 1'b0;
      tgt             <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      cp0_we          <= 1'b0;
      cp0_epc_we      <= 1'b0;
      cp0_badvaddr_we <= 1'b0;
      cp0_clr_exl     <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state        <= FLUSH;
            cnt          <= '0;
            flush        <= 1'b1;
            stall        <= 1'b1;
            is_eret      <= ~win_exc;
            is_adr       <= win_adr;
            epc_upd      <= ~status_exl;
            tgt          <= win_exc ? EXC_VECTOR : epc_in;
            cp0_exccode  <= win_code;
            cp0_epc      <= mem_in_delay ? (mem_pc - 32'd4) : mem_pc;
            cp0_bd       <= mem_in_delay;
            cp0_badvaddr <= mem_badvaddr;
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state           <= COMMIT;
            flush           <= 1'b0;
            cp0_we          <= ~is_eret;
            cp0_epc_we      <= ~is_eret & epc_upd;
            cp0_badvaddr_we <= ~is_eret & is_adr;
            cp0_clr_exl     <= is_eret;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        COMMIT: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= tgt;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXC_SEQ_COUNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_count <= '0;
    end else if (state == COMMIT && !is_eret) begin
      exc_count <= exc_count + 32'd1;
    end
  end
`else
  assign exc_count = '0;
`endif

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Sequences the precise exception/ERET flow at the MEM stage of the MIPS pipeline.
- Prioritises pending exception and interrupt requests.
- Drives pipeline flush and stall for a fixed window.
- Issues one-cycle CP0 update strobes (ExcCode, EPC, BD, BadVAddr, EXL).
- Hands the new fetch PC to IF over a valid/ready handshake.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt
FLUSH_CYCLES, 2, cycles flush is held (range 1..7)

Ports:
clk  in  1  clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  MEM-stage instruction valid
mem_pc  in  32  MEM-stage PC
mem_in_delay  in  1  MEM instruction is in a branch delay slot
mem_badvaddr  in  32  faulting address (fetch or load/store)
mem_exc  in  6  [0]AdEL [1]AdES [2]RI [3]Ov [4]Sys [5]Bp
mem_eret  in  1  MEM instruction is ERET
hw_int  in  6  asynchronous hardware interrupt lines
sw_int  in  2  Cause.IP[1:0]
status_im  in  8  Status.IM
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
epc_in  in  32  current CP0 EPC
redirect_ready  in  1  IF accepts redirect
flush  out  1  kill IF..MEM contents
stall  out  1  freeze PC and pipeline registers
redirect_valid  out  1  redirect_pc valid
redirect_pc  out  32  new fetch PC
cp0_we  out  1  strobe: write Cause.ExcCode and set EXL
cp0_exccode  out  5  ExcCode value
cp0_epc_we  out  1  strobe: write EPC and Cause.BD
cp0_epc  out  32  EPC value
cp0_bd  out  1  BD value
cp0_badvaddr_we  out  1  strobe: write BadVAddr
cp0_badvaddr  out  32  BadVAddr value
cp0_clr_exl  out  1  strobe: clear EXL (ERET)
busy  out  1  state != IDLE
exc_count  out  32  taken-exception counter (see Optional Feature)

Behaviour:
- Reset (any time, including mid-sequence): state IDLE; counter 0; every output 0; interrupt synchroniser 0.
- hw_int passes through a 2-flop synchroniser to give hw_s.
- int_pend = |({hw_s, sw_int} & status_im) & status_ie & ~status_exl.
- Capture is evaluated in IDLE only, and only when mem_valid=1.
- Priority, highest first, with ExcCode:
  - Int = 0
  - AdEL = 4
  - AdES = 5
  - RI = 10
  - Ov = 12
  - Sys = 8
  - Bp = 9
  - ERET (taken only if none of the above)
- On capture, latch the following; requests arriving outside IDLE are ignored.
  - exccode.
  - epc = mem_in_delay ? mem_pc-4 : mem_pc (wrap mod 2^32).
  - bd = mem_in_delay.
  - badvaddr = mem_badvaddr.
  - is_adr = the winning request is AdEL or AdES.
  - epc_upd = ~status_exl.
  - tgt = ERET ? epc_in : EXC_VECTOR.
- FSM:
  - IDLE -> FLUSH on capture.
  - FLUSH: flush=1, stall=1; count 0..FLUSH_CYCLES-1, then go to COMMIT.
  - COMMIT, exactly one cycle, stall=1:
    - exception: cp0_we=1; cp0_epc_we=epc_upd; cp0_badvaddr_we=is_adr.
    - ERET: cp0_clr_exl=1; no other strobe.
    - Always go to REDIRECT.
  - REDIRECT: redirect_valid=1 and redirect_pc=tgt held stable, stall=1, until redirect_valid & redirect_ready, then IDLE.
  - First capture possible the cycle after the handshake.
- The cp0_* data outputs hold the latched values from capture until the next capture.
- Exception-to-handshake latency with redirect_ready=1: FLUSH_CYCLES+2 cycles.
- A synchronous exception with status_exl=1 is still taken, with cp0_epc_we=0.
- Interrupts are masked while EXL=1.
- Several mem_exc bits set at once: only the highest-priority one is reported.

Optional Feature:
EXC_SEQ_COUNT_EN
- Defined: exc_count increments by 1 on each exception COMMIT (not on ERET), wraps at 2^32, reset 0.
- Undefined: exc_count tied to 0 and no counter logic is built.

Test Plan:
1. Sys on mem_pc=0x80001000, in_delay=0, EXL=0, ready=1:
   - flush high for 2 cycles;
   - COMMIT: cp0_exccode=8, cp0_epc=0x80001000, cp0_bd=0, cp0_epc_we=1, cp0_badvaddr_we=0;
   - redirect_pc=0xBFC00380 at cycle 4.
2. AdEL+Ov together, mem_pc=0x80002004, in_delay=1, badvaddr=0x00000003:
   - exccode=4, epc=0x80002000, bd=1, cp0_badvaddr_we=1, badvaddr=0x00000003.
3. hw_int[2]=1, IM[4]=1, IE=1, EXL=0, mem_valid=1:
   - after the 2-cycle synchroniser, exccode=0 taken;
   - repeat with EXL=1: no capture, busy stays 0.
4. ERET with epc_in=0x80003000:
   - COMMIT asserts cp0_clr_exl only;
   - redirect_pc=0x80003000;
   - with ready low for 3 cycles, redirect_valid and redirect_pc stay stable and stall stays 1.
5. resetn low during FLUSH:
   - all outputs 0 immediately;
   - after release, a new Bp is sequenced normally with exccode=9.
6. With EXC_SEQ_COUNT_EN defined:
   - 3 exceptions plus 1 ERET give exc_count=3;
   - undefined, exc_count=0.
